crc_frame_checker: RTL and testbench

- Receive-side companion to the CRC generator LFSR.
- Consumes a serial frame: payload bits first, then the transmitted CRC, MSB first.
- Runs the same configurable MSB-first CRC LFSR over the payload, captures the received CRC and reports pass/fail.
- Sits between the serial input pins and the status/readback logic.

---
 rtl/crc_frame_checker.sv | 173 +++++++++++++++++
 tb/tb_crc_frame_checker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: runs a configurable MSB-first CRC LFSR over a serial
// payload, captures the transmitted CRC that follows it, and reports pass/fail.
module crc_frame_checker #(
   parameter int WIDTH     = 32,
   parameter int BIT_COUNT = 5,
   parameter int LEN_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_COUNT-1:0] bitwidth,
   input  logic [WIDTH-1:0]     taps,
   input  logic [WIDTH-1:0]     init_value,
   input  logic [LEN_BITS-1:0]  payload_len,
   input  logic                 in_valid,
   input  logic                 in_data,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 crc_ok,
   output logic [WIDTH-1:0]     crc_calc,
   output logic [WIDTH-1:0]     crc_rx
);

   // The counter must hold either a payload length or a CRC width N (up to 2^BIT_COUNT).
   localparam int CNT_W = (LEN_BITS > BIT_COUNT + 1) ? LEN_BITS : BIT_COUNT + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_CRCRX,
      ST_DONE
   } state_t;

   function automatic logic [WIDTH-1:0] width_mask(input logic [BIT_COUNT-1:0] bw);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i <= int'(bw)) m[i] = 1'b1;
      end
      return m;
   endfunction

   state_t               state_q, state_d;
   logic [BIT_COUNT-1:0] bitwidth_q, bitwidth_d;
   logic [WIDTH-1:0]     mask_q, mask_d;
   logic [WIDTH-1:0]     taps_q, taps_d;
   logic [WIDTH-1:0]     lfsr_q, lfsr_d;
   logic [WIDTH-1:0]     rx_q, rx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 crc_ok_q, crc_ok_d;
   logic [WIDTH-1:0]     crc_calc_q, crc_calc_d;
   logic [WIDTH-1:0]     crc_rx_q, crc_rx_d;

   logic [WIDTH-1:0]     start_mask;
   logic [WIDTH-1:0]     top_bit;
   logic [WIDTH-1:0]     rx_next;
   logic [CNT_W-1:0]     crc_len;
   logic [CNT_W-1:0]     crc_len_start;
   logic                 fb;
   logic                 last_bit;

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      bitwidth_d = bitwidth_q;
      mask_d     = mask_q;
      taps_d     = taps_q;
      lfsr_d     = lfsr_q;
      rx_d       = rx_q;
      cnt_d      = cnt_q;
      crc_ok_d   = crc_ok_q;
      crc_calc_d = crc_calc_q;
      crc_rx_d   = crc_rx_q;

      start_mask    = width_mask(bitwidth);
      top_bit       = mask_q & ~(mask_q >> 1);
      fb            = in_data ^ (|(lfsr_q & top_bit));
      rx_next       = ((rx_q << 1) | WIDTH'(in_data)) & mask_q;
      crc_len       = CNT_W'(bitwidth_q) + CNT_W'(1);
      crc_len_start = CNT_W'(bitwidth) + CNT_W'(1);
      last_bit      = (cnt_q == CNT_W'(1));

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               bitwidth_d = bitwidth;
               mask_d     = start_mask;
               taps_d     = taps & start_mask;
               lfsr_d     = init_value & start_mask;
               rx_d       = '0;
               crc_ok_d   = 1'b0;
               if (payload_len != '0) begin
                  cnt_d   = CNT_W'(payload_len);
                  state_d = ST_PAYLOAD;
               end else begin
                  cnt_d   = crc_len_start;
                  state_d = ST_CRCRX;
               end
            end
         end

         ST_PAYLOAD: begin
            if (in_valid) begin
               lfsr_d = ((lfsr_q << 1) & mask_q) ^ (fb ? taps_q : '0);
               if (last_bit) begin
                  cnt_d   = crc_len;
                  state_d = ST_CRCRX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         ST_CRCRX: begin
            if (in_valid) begin
               rx_d  = rx_next;
               cnt_d = cnt_q - CNT_W'(1);
               // Results are registered on the final bit so they appear together with done.
               if (last_bit) begin
                  crc_ok_d   = (rx_next == lfsr_q);
                  crc_calc_d = lfsr_q;
                  crc_rx_d   = rx_next;
                  state_d    = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         bitwidth_q <= '0;
         mask_q     <= '0;
         taps_q     <= '0;
         lfsr_q     <= '0;
         rx_q       <= '0;
         cnt_q      <= '0;
         crc_ok_q   <= 1'b0;
         crc_calc_q <= '0;
         crc_rx_q   <= '0;
      end else begin
         state_q    <= state_d;
         bitwidth_q <= bitwidth_d;
         mask_q     <= mask_d;
         taps_q     <= taps_d;
         lfsr_q     <= lfsr_d;
         rx_q       <= rx_d;
         cnt_q      <= cnt_d;
         crc_ok_q   <= crc_ok_d;
         crc_calc_q <= crc_calc_d;
         crc_rx_q   <= crc_rx_d;
      end
   end

   assign in_ready = (state_q == ST_PAYLOAD) || (state_q == ST_CRCRX);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign crc_ok   = crc_ok_q;
   assign crc_calc = crc_calc_q;
   assign crc_rx   = crc_rx_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: directed CRC-8/16/32 frames plus
// randomized frames, all compared against a bit-serial polynomial reference model.
module tb_crc_frame_checker;

   localparam int WIDTH     = 32;
   localparam int BIT_COUNT = 5;
   localparam int LEN_BITS  = 16;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [BIT_COUNT-1:0] bitwidth;
   logic [WIDTH-1:0]     taps;
   logic [WIDTH-1:0]     init_value;
   logic [LEN_BITS-1:0]  payload_len;
   logic                 in_valid;
   logic                 in_data;
   logic                 in_ready;
   logic                 busy;
   logic                 done;
   logic                 crc_ok;
   logic [WIDTH-1:0]     crc_calc;
   logic [WIDTH-1:0]     crc_rx;

   int n_checks;
   int n_errors;

   // Result values the DUT is expected to be holding between frames.
   logic [31:0] hold_calc;
   logic [31:0] hold_rx;
   logic        hold_ok;

   bit pq[$];

   crc_frame_checker #(
      .WIDTH(WIDTH),
      .BIT_COUNT(BIT_COUNT),
      .LEN_BITS(LEN_BITS)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .start(start),
      .bitwidth(bitwidth),
      .taps(taps),
      .init_value(init_value),
      .payload_len(payload_len),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .busy(busy),
      .done(done),
      .crc_ok(crc_ok),
      .crc_calc(crc_calc),
      .crc_rx(crc_rx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Polynomial division remainder computed bit by bit on a 64-bit integer.
   function automatic logic [31:0] ref_crc(input bit bits[$], input int n,
                                           input logic [31:0] taps_v, input logic [31:0] init_v);
      longint unsigned mask = (64'd1 << n) - 64'd1;
      longint unsigned r    = {32'd0, init_v} & mask;
      longint unsigned t    = {32'd0, taps_v} & mask;
      longint unsigned msb;
      foreach (bits[i]) begin
         msb = (r >> (n - 1)) & 64'd1;
         r   = (r << 1) & mask;
         if ((bits[i] ? 64'd1 : 64'd0) != msb) r = r ^ t;
      end
      return r[31:0];
   endfunction

   task automatic push_string(input string s);
      byte c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         for (int b = 7; b >= 0; b--) pq.push_back(c[b]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_crc_ok"}, crc_ok, 0);
      check({tag, "_crc_calc"}, crc_calc, 0);
      check({tag, "_crc_rx"}, crc_rx, 0);
   endtask

   // Drives one frame from a negedge; abort_at >= 0 resets the DUT after that many bits.
   task automatic run_frame(input string tag, input int n, input logic [31:0] taps_v,
                            input logic [31:0] init_v, input bit pay[$], input logic [31:0] crc_tx,
                            input bit gaps, input int start_mid, input int abort_at,
                            input bit start_in_done);
      logic [31:0] mask32;
      logic [31:0] exp_calc;
      logic [31:0] exp_rx;
      logic        exp_ok;
      bit          all[$];
      bit          ready_bad;
      bit          early_done;
      int          ngap;

      mask32   = 32'((64'd1 << n) - 64'd1);
      exp_calc = ref_crc(pay, n, taps_v, init_v);
      exp_rx   = crc_tx & mask32;
      exp_ok   = (exp_calc == exp_rx);
      all      = pay;
      for (int i = n - 1; i >= 0; i--) all.push_back(crc_tx[i]);
      ready_bad  = 1'b0;
      early_done = 1'b0;

      start       = 1'b1;
      bitwidth    = BIT_COUNT'(n - 1);
      taps        = taps_v | ($urandom & ~mask32);
      init_value  = init_v | ($urandom & ~mask32);
      payload_len = LEN_BITS'(pay.size());
      in_valid    = 1'($urandom);
      in_data     = 1'($urandom);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      check({tag, "_ok_cleared"}, crc_ok, 0);
      check({tag, "_calc_held"}, crc_calc, hold_calc);
      check({tag, "_rx_held"}, crc_rx, hold_rx);

      for (int idx = 0; idx < all.size(); idx++) begin
         ngap = 0;
         while (gaps && ngap < 4 && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 1'($urandom);
            if (done) early_done = 1'b1;
            @(negedge clk);
            ngap++;
         end
         if (idx == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs({tag, "_abort"});
            hold_calc = '0;
            hold_rx   = '0;
            hold_ok   = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check({tag, "_abort_no_done"}, done, 0);
            check({tag, "_abort_idle"}, busy, 0);
            return;
         end
         in_valid = 1'b1;
         in_data  = all[idx];
         if (idx == start_mid) begin
            start       = 1'b1;
            bitwidth    = BIT_COUNT'($urandom);
            payload_len = LEN_BITS'($urandom);
            init_value  = $urandom;
         end
         if (!in_ready) ready_bad = 1'b1;
         if (done) early_done = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      in_valid = 1'b0;

      check({tag, "_done_latency"}, done, 1);
      check({tag, "_ready_during_frame"}, ready_bad, 0);
      check({tag, "_no_early_done"}, early_done, 0);
      check({tag, "_crc_ok"}, crc_ok, exp_ok);
      check({tag, "_crc_calc"}, crc_calc, exp_calc);
      check({tag, "_crc_rx"}, crc_rx, exp_rx);
      hold_calc = exp_calc;
      hold_rx   = exp_rx;
      hold_ok   = exp_ok;

      if (start_in_done) begin
         start       = 1'b1;
         bitwidth    = BIT_COUNT'($urandom);
         payload_len = LEN_BITS'($urandom_range(1, 100));
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_pulse_end"}, done, 0);
      check({tag, "_idle_after_done"}, busy, 0);
      check({tag, "_ok_held"}, crc_ok, hold_ok);
   endtask

   initial begin
      logic [31:0] tp;
      logic [31:0] iv;
      logic [31:0] good;
      int          nr;
      int          len;

      n_checks  = 0;
      n_errors  = 0;
      hold_calc = '0;
      hold_rx   = '0;
      hold_ok   = 1'b0;

      rst_n       = 1'b0;
      start       = 1'b0;
      bitwidth    = '0;
      taps        = '0;
      init_value  = '0;
      payload_len = '0;
      in_valid    = 1'b0;
      in_data     = 1'b0;

      // Reset held with random activity, including start pulses.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start       = 1'($urandom);
         bitwidth    = BIT_COUNT'($urandom);
         taps        = $urandom;
         init_value  = $urandom;
         payload_len = LEN_BITS'($urandom);
         in_valid    = 1'($urandom);
         in_data     = 1'($urandom);
      end
      @(negedge clk);
      check_reset_outputs("reset");
      start    = 1'b0;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("reset_release_idle", busy, 0);

      // CRC-8 pass and fail, the latter with a start pulse mid-frame.
      pq.delete();
      for (int b = 7; b >= 0; b--) pq.push_back(b == 0);
      run_frame("crc8_pass", 8, 32'h07, 32'h00, pq, 32'h07, 1'b0, -1, -1, 1'b0);
      check("crc8_pass_const_calc", crc_calc, 32'h07);
      check("crc8_pass_const_ok", crc_ok, 1);
      run_frame("crc8_fail", 8, 32'h07, 32'h00, pq, 32'h06, 1'b0, 5, -1, 1'b0);
      check("crc8_fail_const_rx", crc_rx, 32'h06);
      check("crc8_fail_const_ok", crc_ok, 0);

      // CRC-16/CCITT-FALSE with in_valid gaps.
      pq.delete();
      push_string("123456789");
      run_frame("crc16", 16, 32'h1021, 32'hFFFF, pq, 32'h29B1, 1'b1, -1, -1, 1'b0);
      check("crc16_const_calc", crc_calc, 32'h29B1);

      // CRC-32/MPEG-2, start ignored in DONE, then back-to-back frame.
      run_frame("crc32_a", 32, 32'h04C11DB7, 32'hFFFFFFFF, pq, 32'h0376E6E7, 1'b0, -1, -1, 1'b1);
      check("crc32_a_const_calc", crc_calc, 32'h0376E6E7);
      run_frame("crc32_b", 32, 32'h04C11DB7, 32'hFFFFFFFF, pq, 32'h0376E6E7, 1'b1, -1, -1, 1'b0);
      check("crc32_b_const_ok", crc_ok, 1);

      // Empty payload: the computed CRC is the seed itself.
      pq.delete();
      run_frame("len0", 8, 32'h07, 32'hA5, pq, 32'hA5, 1'b0, -1, -1, 1'b0);
      check("len0_const_ok", crc_ok, 1);

      // Mid-frame reset after 20 payload bits, then a clean frame.
      pq.delete();
      push_string("123456789");
      run_frame("abort", 16, 32'h1021, 32'hFFFF, pq, 32'h29B1, 1'b0, -1, 20, 1'b0);
      pq.delete();
      for (int b = 7; b >= 0; b--) pq.push_back(b == 0);
      run_frame("after_abort", 8, 32'h07, 32'h00, pq, 32'h07, 1'b0, -1, -1, 1'b0);

      // One-bit CRC (parity) over a random payload.
      pq.delete();
      for (int i = 0; i < 13; i++) pq.push_back(1'($urandom));
      run_frame("parity", 1, 32'h1, 32'h0, pq, ref_crc(pq, 1, 32'h1, 32'h0), 1'b1, -1, -1, 1'b0);

      // Random configurations, half with a correct CRC and half with a random one.
      for (int f = 0; f < 24; f++) begin
         nr  = $urandom_range(1, 32);
         len = $urandom_range(0, 40);
         tp  = $urandom;
         iv  = $urandom;
         pq.delete();
         for (int i = 0; i < len; i++) pq.push_back(1'($urandom));
         good = ref_crc(pq, nr, tp, iv);
         run_frame($sformatf("rand%0d", f), nr, tp, iv, pq,
                   ($urandom_range(0, 1) == 1) ? good : $urandom,
                   1'b1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + nr - 1) : -1,
                   -1, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
